// File: rtl/difftest_wb_pkg.sv
// Shared types and helpers for the difftest integer-writeback scheduler.
// Event fields are fixed here so that the buffer entry is a single packed word.
package difftest_wb_pkg;

    localparam int WB_ADDR_W   = 6;
    localparam int WB_DATA_W   = 64;
    localparam int WB_COREID_W = 8;
    localparam int DROP_CNT_W  = 16;
    localparam int MAX_PORTS   = 16;

    typedef struct packed {
        logic [WB_ADDR_W-1:0]   addr;
        logic [WB_DATA_W-1:0]   data;
        logic [WB_COREID_W-1:0] coreid;
    } int_wb_ev_t;

    function automatic logic [4:0] popcount_ports(input logic [MAX_PORTS-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/difftest_wb_fifo.sv
// Multi-push, single-pop circular event buffer. Pushed events arrive already
// compacted: slots 0..i_push_cnt-1 are written from wr_ptr upward, wrapping per slot.
module difftest_wb_fifo
    import difftest_wb_pkg::*;
#(
    parameter int  NUM_PORTS = 4,
    parameter int  DEPTH     = 16,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1,
    localparam int OFF_W     = $clog2(NUM_PORTS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic [OFF_W-1:0] i_push_cnt,
    input  int_wb_ev_t       i_push_ev [NUM_PORTS],
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic [PTR_W-1:0] o_wr_ptr,
    output int_wb_ev_t       o_head_ev
);

    int_wb_ev_t       r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OFF_W-1:0] w_push_cnt;

    // A flush discards whatever is being pushed alongside it.
    assign w_push_cnt = i_flush ? '0 : i_push_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (i_flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
            r_count  <= r_count + CNT_W'(w_push_cnt) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (OFF_W'(k) < w_push_cnt) begin
                r_mem[r_wr_ptr + PTR_W'(k)] <= i_push_ev[k];
            end
        end
    end

    assign o_count   = r_count;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_wr_ptr  = r_wr_ptr;
    assign o_head_ev = r_mem[r_rd_ptr];

    a_count_le_depth: assert property (@(posedge clock) disable iff (!reset)
        r_count <= CNT_W'(DEPTH));

    a_no_pop_when_empty: assert property (@(posedge clock) disable iff (!reset)
        i_pop |-> (r_count != '0));

endmodule

// File: rtl/difftest_int_wb_sched.sv
// Serializes per-port integer writeback events into one in-order difftest stream,
// dropping whole cycles of events (and counting them) when the buffer lacks room.
module difftest_int_wb_sched
    import difftest_wb_pkg::*;
#(
    parameter int  NUM_PORTS = 4,
    parameter int  DEPTH     = 16,
    parameter int  ADDR_W    = WB_ADDR_W,
    parameter int  DATA_W    = WB_DATA_W,
    parameter int  COREID_W  = WB_COREID_W,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1,
    localparam int OFF_W     = $clog2(NUM_PORTS + 1),
    localparam int SUM_W     = DROP_CNT_W + 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0] in_address,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    output logic                        in_ready,
    input  logic                        flush,
    input  logic [COREID_W-1:0]         coreid,
    input  logic                        out_ready,
    output logic                        out_enable,
    output logic                        out_valid,
    output logic [ADDR_W-1:0]           out_address,
    output logic [DATA_W-1:0]           out_data,
    output logic [COREID_W-1:0]         out_coreid,
    output logic                        overflow,
    output logic [DROP_CNT_W-1:0]       drop_count
);

    int_wb_ev_t            w_port_ev [NUM_PORTS];
    int_wb_ev_t            w_slot_ev [NUM_PORTS];
    int_wb_ev_t            w_head;
    logic [OFF_W-1:0]      w_prefix  [NUM_PORTS];
    logic [OFF_W-1:0]      w_acc;
    logic [OFF_W-1:0]      w_push_cnt;
    logic [OFF_W-1:0]      w_accept_cnt;
    logic [CNT_W-1:0]      w_count;
    logic [PTR_W-1:0]      w_rd_ptr;
    logic [PTR_W-1:0]      w_wr_ptr;
    logic                  w_in_ready;
    logic                  w_pop;
    logic                  w_drop;
    logic [SUM_W-1:0]      w_drop_sum;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_count;

    // Prefix sum of in_valid gives each valid port its slot offset from wr_ptr.
    always_comb begin
        w_acc = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_port_ev[p].addr   = in_address[p*ADDR_W +: ADDR_W];
            w_port_ev[p].data   = in_data[p*DATA_W +: DATA_W];
            w_port_ev[p].coreid = coreid;
            w_prefix[p]         = w_acc;
            w_acc               = w_acc + OFF_W'(in_valid[p]);
        end
    end

    assign w_push_cnt = w_acc;

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_slot_ev[k] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (in_valid[p] && (w_prefix[p] == OFF_W'(k))) begin
                    w_slot_ev[k] = w_port_ev[p];
                end
            end
        end
    end

    assign w_in_ready   = (w_count <= CNT_W'(DEPTH - NUM_PORTS));
    assign w_accept_cnt = w_in_ready ? w_push_cnt : '0;
    assign w_pop        = (w_count != '0) && out_ready && !flush;
    assign w_drop       = !flush && !w_in_ready && (|in_valid);

    difftest_wb_fifo #(
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_flush    (flush),
        .i_push_cnt (w_accept_cnt),
        .i_push_ev  (w_slot_ev),
        .i_pop      (w_pop),
        .o_count    (w_count),
        .o_rd_ptr   (w_rd_ptr),
        .o_wr_ptr   (w_wr_ptr),
        .o_head_ev  (w_head)
    );

    assign w_drop_sum = {1'b0, r_drop_count} + SUM_W'(popcount_ports(MAX_PORTS'(in_valid)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow   <= 1'b1;
            r_drop_count <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = (w_count != '0);
    assign out_enable  = w_pop;
    assign out_address = w_head.addr;
    assign out_data    = w_head.data;
    assign out_coreid  = w_head.coreid;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;

    a_ptr_count_consistent: assert property (@(posedge clock) disable iff (!reset)
        (w_wr_ptr - w_rd_ptr) == w_count[PTR_W-1:0]);

endmodule

// File: tb/tb_difftest_int_wb_sched.sv
// Bench for difftest_int_wb_sched: directed table, hand sequences and random traffic,
// all checked against a queue-based model of the event stream.
module tb_difftest_int_wb_sched;

    localparam int NP    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int CW    = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NP-1:0]     in_valid = '0;
    logic [NP*AW-1:0]  in_address = '0;
    logic [NP*DW-1:0]  in_data = '0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic [CW-1:0]     coreid = 8'h3C;
    logic              out_ready = 1'b0;
    logic              out_enable;
    logic              out_valid;
    logic [AW-1:0]     out_address;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_coreid;
    logic              overflow;
    logic [15:0]       drop_count;

    always #5 clock = ~clock;

    difftest_int_wb_sched #(
        .NUM_PORTS (NP),
        .DEPTH     (DEPTH),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .COREID_W  (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_address  (in_address),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .flush       (flush),
        .coreid      (coreid),
        .out_ready   (out_ready),
        .out_enable  (out_enable),
        .out_valid   (out_valid),
        .out_address (out_address),
        .out_data    (out_data),
        .out_coreid  (out_coreid),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    int n_err = 0;
    int n_checks = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } mev_t;

    mev_t mq[$];
    logic m_ovf = 1'b0;
    int   m_drop = 0;

    typedef struct {
        logic [NP-1:0]    v;
        logic [NP*AW-1:0] a;
        logic [NP*DW-1:0] d;
        logic             ordy;
        logic             e_valid;
        logic [AW-1:0]    e_addr;
        logic [DW-1:0]    e_data;
        logic             e_en;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic rand_ports();
        for (int p = 0; p < NP; p++) begin
            in_address[p*AW +: AW] = AW'($urandom);
            in_data[p*DW +: DW]    = {$urandom, $urandom};
        end
    endtask

    // Called at a negedge with inputs already driven; checks, then steps the model over one posedge.
    task automatic cycle();
        logic e_valid, e_ready, e_en;
        int n;
        #1;
        e_valid = (mq.size() != 0);
        e_ready = (mq.size() <= DEPTH - NP);
        e_en    = e_valid && out_ready && !flush;
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("in_ready", 64'(in_ready), 64'(e_ready));
        chk("out_enable", 64'(out_enable), 64'(e_en));
        if (e_valid) begin
            chk("out_address", 64'(out_address), 64'(mq[0].a));
            chk("out_data", out_data, mq[0].d);
            chk("out_coreid", 64'(out_coreid), 64'(mq[0].c));
        end
        chk("count", 64'(dut.w_count), 64'(mq.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        @(posedge clock);
        if (flush) begin
            mq.delete();
        end else begin
            if (e_en) void'(mq.pop_front());
            n = $countones(in_valid);
            if (e_ready) begin
                for (int p = 0; p < NP; p++) begin
                    if (in_valid[p]) mq.push_back('{in_address[p*AW +: AW], in_data[p*DW +: DW], coreid});
                end
            end else if (n > 0) begin
                m_ovf  = 1'b1;
                m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        in_valid  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [AW-1:0] first_addr;
        int saved_drop;

        tbl[0] = '{4'b1010, {6'd7, 6'd0, 6'd3, 6'd0}, {64'h33, 64'h0, 64'h11, 64'h0}, 1'b1, 1'b0, 6'd0, 64'h0, 1'b0};
        tbl[1] = '{4'b0001, {18'd0, 6'd1}, {192'd0, 64'h55}, 1'b1, 1'b1, 6'd3, 64'h11, 1'b1};
        tbl[2] = '{4'b0000, '0, '0, 1'b1, 1'b1, 6'd7, 64'h33, 1'b1};
        tbl[3] = '{4'b0000, '0, '0, 1'b1, 1'b1, 6'd1, 64'h55, 1'b1};
        tbl[4] = '{4'b0000, '0, '0, 1'b1, 1'b0, 6'd0, 64'h0, 1'b0};

        do_reset();

        // Reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_enable", 64'(out_enable), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        @(negedge clock);

        // Ordering table: older cycle first, lower port first, one cycle latency
        for (int i = 0; i < 5; i++) begin
            in_valid   = tbl[i].v;
            in_address = tbl[i].a;
            in_data    = tbl[i].d;
            out_ready  = tbl[i].ordy;
            #1;
            chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].e_valid));
            chk("tbl_out_enable", 64'(out_enable), 64'(tbl[i].e_en));
            if (tbl[i].e_valid) begin
                chk("tbl_out_address", 64'(out_address), 64'(tbl[i].e_addr));
                chk("tbl_out_data", out_data, tbl[i].e_data);
            end
            cycle();
        end

        // Fill to DEPTH with out_ready low, then one more push must be dropped whole
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 4'b1111;
            rand_ports();
            if (i == 0) first_addr = in_address[AW-1:0];
            cycle();
        end
        in_valid = 4'b1111;
        rand_ports();
        #1;
        chk("full_count", 64'(dut.w_count), 64'd16);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cycle();
        in_valid = '0;
        #1;
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_drop_count", 64'(drop_count), 64'd4);
        chk("full_count_kept", 64'(dut.w_count), 64'd16);
        chk("full_head_kept", 64'(out_address), 64'(first_addr));

        // Asynchronous reset mid-stream, between clock edges
        #1;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(dut.w_count), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        chk("arst_drop_count", 64'(drop_count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        // Walk pointers to 14 with overlapped push/pop, then a wrapping 3-slot push
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 4'b0001;
            rand_ports();
            cycle();
        end
        in_valid = '0;
        cycle();
        chk("wrap_rd_ptr", 64'(dut.w_rd_ptr), 64'd14);
        chk("wrap_wr_ptr", 64'(dut.w_wr_ptr), 64'd14);
        in_valid = 4'b1011;
        rand_ports();
        in_address[0*AW +: AW] = 6'd20;
        in_address[1*AW +: AW] = 6'd21;
        in_address[3*AW +: AW] = 6'd23;
        coreid = 8'h5A;
        cycle();
        chk("wrap_wr_ptr_after", 64'(dut.w_wr_ptr), 64'd1);
        coreid   = 8'hA5;
        in_valid = '0;
        for (int i = 0; i < 4; i++) cycle();

        // Flush with concurrent push from count 6
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        rand_ports();
        cycle();
        in_valid = 4'b0011;
        rand_ports();
        cycle();
        saved_drop = m_drop;
        flush      = 1'b1;
        out_ready  = 1'b1;
        in_valid   = 4'b1111;
        rand_ports();
        cycle();
        flush    = 1'b0;
        in_valid = '0;
        #1;
        chk("flush_count", 64'(dut.w_count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_drop_count", 64'(drop_count), 64'(saved_drop));
        @(negedge clock);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = NP'($urandom);
            out_ready = ($urandom % 10) < 7;
            flush     = ($urandom % 32) == 0;
            if ($urandom % 16 == 0) coreid = CW'($urandom);
            rand_ports();
            cycle();
        end
        flush = 1'b0;

        // drop_count saturation
        do_reset();
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            rand_ports();
            cycle();
        end
        for (int i = 0; i < 16383; i++) cycle();
        in_valid = 4'b0011;
        cycle();
        chk("sat_drop_fffe", 64'(drop_count), 64'hFFFE);
        in_valid = 4'b1111;
        cycle();
        chk("sat_drop_ffff", 64'(drop_count), 64'hFFFF);
        cycle();
        chk("sat_drop_hold", 64'(drop_count), 64'hFFFF);
        in_valid = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
